// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter family:
// FSM encodings, width rule and clog2 helper.
package fir_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MAC  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic bit width_ok(
    input int n1,
    input int n2,
    input int n3
  );
    return n3 >= n1 + n2;
  endfunction

endpackage

// File: rtl/fir_coef_rf.sv
// Coefficient register file: one synchronous write
// port, one combinational read port, async clear.
module fir_coef_rf
  import fir_pkg::*;
#(
  parameter int N1   = 8,
  parameter int TAPS = 16,
  parameter int AW   = clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N1-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [N1-1:0] rdata
);

  logic [N1-1:0] mem [TAPS];
  logic          in_range;

  assign in_range = {1'b0, waddr} < (AW+1)'(TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge value, so a same-cycle write is not forwarded
  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_serial_filter.sv
// Programmable FIR filter with one time-shared MAC,
// one tap per cycle, valid/ready input and pulsed output.
module fir_serial_filter
  import fir_pkg::*;
#(
  parameter int N1   = 8,
  parameter int N2   = 16,
  parameter int N3   = 32,
  parameter int TAPS = 16,
  parameter int AW   = clog2(TAPS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENABLE,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [N1-1:0] coef_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N2-1:0] input_data,
  output logic          out_valid,
  output logic [N3-1:0] filtered_data,
  output logic [N2-1:0] sample_T
);

  if (!width_ok(N1, N2, N3)) begin : g_bad_width
    $error("fir_serial_filter: N3 must be >= N1+N2");
  end
  if (TAPS < 2) begin : g_bad_taps
    $error("fir_serial_filter: TAPS must be >= 2");
  end

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  logic [0:0]            state;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         wr_nxt;
  logic [AW-1:0]         k;
  logic [AW-1:0]         rd_idx;
  logic [AW:0]           wrap_idx;
  logic [N2-1:0]         smp_buf [TAPS];
  logic [N1-1:0]         coef_rd;
  logic signed [N1+N2-1:0] prod;
  logic [N3-1:0]         prod_ext;
  logic [N3-1:0]         acc;
  logic [N3-1:0]         acc_nxt;
  logic                  accept;

  assign in_ready = ENABLE && (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_nxt   = (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);

  // Tap k reads the k-th newest sample; modulo done without power-of-2 masking
  assign wrap_idx = {1'b0, wr_ptr} + (AW+1)'(TAPS) - {1'b0, k};
  assign rd_idx   = (wr_ptr >= k) ? wr_ptr - k : wrap_idx[AW-1:0];

  assign prod     = $signed(coef_rd) * $signed(smp_buf[rd_idx]);
  assign prod_ext = N3'(prod);
  assign acc_nxt  = acc + prod_ext;

  fir_coef_rf #(
    .N1   (N1),
    .TAPS (TAPS),
    .AW   (AW)
  ) u_coef (
    .clk   (CLK),
    .rst   (RST),
    .we    (coef_we),
    .waddr (coef_addr),
    .wdata (coef_data),
    .raddr (k),
    .rdata (coef_rd)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < TAPS; i++) smp_buf[i] <= '0;
    end else if (accept) begin
      smp_buf[wr_nxt] <= input_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      wr_ptr        <= LAST;
      k             <= '0;
      acc           <= '0;
      out_valid     <= 1'b0;
      filtered_data <= '0;
      sample_T      <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_ptr   <= wr_nxt;
            sample_T <= input_data;
            acc      <= '0;
            k        <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          k   <= k + AW'(1);
          if (k == LAST) begin
            filtered_data <= acc_nxt;
            out_valid     <= 1'b1;
            k             <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_serial_filter.md
# fir_serial_filter

Programmable-coefficient FIR filter for the filtering datapath, and the parametrised successor to the fixed fir_filter. Tap count, coefficient width, data width and output width are all parameters. Coefficients load at run time through a write port, and a single time-multiplexed multiply-accumulate unit replaces the per-tap multipliers. Input samples arrive under a valid/ready handshake and each result is flagged with a one-cycle out_valid strobe, so the block can sit between an ADC-rate sample source and a downstream sink or file logger.

## Interface
- N1, 8: coefficient word width, signed two's complement
- N2, 16: input data word width, signed
- N3, 32: output word width, signed; N3 >= N1+N2 required (elaboration error otherwise)
- TAPS, 16: number of taps, >= 2, any integer (not restricted to powers of 2)
- AW, $clog2(TAPS): derived coefficient/sample address width
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- ENABLE  in  1  gates sample acceptance only
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  tap index to write; writes with coef_addr >= TAPS are ignored
- coef_data  in  N1  coefficient value
- in_valid  in  1  input_data holds a sample
- in_ready  out  1  block can accept a sample this cycle
- input_data  in  N2  input sample
- out_valid  out  1  one-cycle pulse, filtered_data updated
- filtered_data  out  N3  last completed output, held between pulses
- sample_T  out  N2  newest accepted sample, held

## Operation
- States are IDLE and MAC. Reset puts the block in IDLE.
- in_ready = ENABLE && state==IDLE (combinational).
- **Accept** (in_valid && in_ready at an edge):
  - wr_ptr advances with wrap, TAPS-1 → 0.
  - The sample is written to buf[wr_ptr].
  - sample_T <= input_data; acc <= 0; k <= 0; state → MAC.
- **MAC** (one tap per cycle, k = 0..TAPS-1):
  - acc += coef[k] * buf[(wr_ptr - k) mod TAPS], so k=0 is the newest sample.
  - The N1×N2 signed product is sign-extended to N3. Accumulation wraps modulo 2^N3, with no saturation.
  - On k==TAPS-1: filtered_data <= acc + product; out_valid <= 1; state → IDLE.
- out_valid has no backpressure. It is high for exactly one cycle per accepted sample.
- **ENABLE** low blocks new accepts. A MAC already in progress still completes and still emits its output.
- **Coefficient writes:**
  - A write lands at its edge in any state.
  - A MAC read of the same tap in the same cycle uses the old value.
  - Writes during MAC therefore affect later taps of the current sample.
  - Writes while ENABLE is low are allowed.
- **Reset values:** in_ready follows from state IDLE and ENABLE; out_valid 0; filtered_data 0; sample_T 0; every coef 0; every buf entry 0; wr_ptr TAPS-1, so the first accept writes buf[0]; acc 0; k 0.
- **Reset mid-MAC:** the partial result is discarded, no out_valid is produced, and history and coefficients are cleared.

## Timing
- Accept at edge E0. MAC cycles run E1..E_TAPS. out_valid is high and filtered_data is valid in the cycle following E_TAPS.
- Latency is TAPS cycles from accept edge to output.
- in_ready is low for TAPS cycles after an accept and high again in the out_valid cycle. The earliest next accept is E_TAPS+1, giving a sustained throughput of one sample per TAPS+1 cycles.
- in_valid with in_ready low is simply not accepted. The source must hold the sample, and no samples are lost.

## Structure
- Shared package fir_pkg holds:
  - state encodings IDLE/MAC
  - the width rule N3 >= N1+N2
  - a clog2 helper shared with fir_filter
- Sub-module fir_coef_rf: TAPS×N1 register file with one synchronous write port, one combinational read port and async reset to 0.
- The sample buffer, pointer, MAC and FSM live in the top module.

## Test plan
1. **Impulse.** TAPS=16, coef[k]=k+1. Input 1 followed by 15 zeros → 16 out_valid pulses with filtered_data = 1,2,…,16, then 0 on subsequent zero inputs.
2. **DC.** All coef=1, input 100 continuously → outputs 100,200,…,1600, then steady at 1600.
3. **Signed extremes.** coef[0]=-128, others 0, input 0x7FFF → filtered_data = 0xFFC00080 (-4194176). Input 0x8000 → 0x00400000 (4194304).
4. **Handshake.** in_valid held high → accepts exactly every 17 cycles, in_ready low for 16 cycles after each accept, out_valid pulses 16 cycles after each accept. With ENABLE dropped mid-MAC, that output still appears and no further accepts occur.
5. **Reset mid-MAC.** Assert RST at MAC cycle 5 → no out_valid, filtered_data=0, sample_T=0. After reloading coefs, the test-1 impulse reproduces test-1 outputs exactly.
6. **Coefficient write during MAC.** Write coef[15]=0 at MAC cycle 3 with the test-1 impulse input → the sixteenth output is 0 instead of 16. Write coef[0]=0 at MAC cycle 3 → the current output is unchanged.
